// File: rtl/bp_pkg.sv
// Shared types for the fetch-stage branch predictor: counter encoding and BHT/BTB entry layout.
package bp_pkg;

  // Widest tag needed (smallest table of 4 entries leaves PC[31:4]).
  localparam int unsigned TAG_MAX_W = 28;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [31:0]          target;
    ctr_t                 ctr;
  } bp_entry_t;

  localparam ctr_t CTR_RESET = WNT;

  localparam bp_entry_t ENTRY_RESET = '{
    valid:  1'b0,
    tag:    '0,
    target: 32'd0,
    ctr:    CTR_RESET
  };

  // Tag is everything above the index and the byte offset, zero-extended to the field width.
  function automatic logic [TAG_MAX_W-1:0] pc_tag(input logic [31:0] pc, input int unsigned idx_w);
    logic [31:0] shifted;
    shifted = pc >> (idx_w + 32'd2);
    return TAG_MAX_W'(shifted);
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating direction counter.
module sat_counter2
  import bp_pkg::*;
(
  input  ctr_t ctr,
  input  logic taken,
  output ctr_t ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      unique case (ctr)
        SNT:     ctr_next = WNT;
        WNT:     ctr_next = WT;
        WT:      ctr_next = ST;
        default: ctr_next = ST;
      endcase
    end else begin
      unique case (ctr)
        ST:      ctr_next = WT;
        WT:      ctr_next = WNT;
        WNT:     ctr_next = SNT;
        default: ctr_next = SNT;
      endcase
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage dynamic branch predictor: 2-bit counter BHT plus direct-mapped BTB,
// updated from Execute, with mispredict/redirect reporting and performance counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcF,
  output logic        predict_takenF,
  output logic [31:0] predict_targetF,
  input  logic        update_validE,
  input  logic [31:0] pcE,
  input  logic        br_takenE,
  input  logic [31:0] targetE,
  input  logic        predicted_takenE,
  input  logic [31:0] predicted_targetE,
  output logic        mispredictE,
  output logic [31:0] redirect_pcE,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  bp_entry_t entry_q [ENTRIES];
  bp_entry_t entry_d [ENTRIES];

  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0]     idx_f, idx_e;
  logic [TAG_MAX_W-1:0] tag_f, tag_e;
  logic                 hit_f, hit_e;
  ctr_t                 ctr_next;

  assign idx_f = pcF[IDX_W+1:2];
  assign idx_e = pcE[IDX_W+1:2];
  assign tag_f = pc_tag(pcF, IDX_W);
  assign tag_e = pc_tag(pcE, IDX_W);

  // Fetch lookup reads the registered table directly: no write-to-read bypass.
  assign hit_f           = entry_q[idx_f].valid && (entry_q[idx_f].tag == tag_f);
  assign predict_takenF  = hit_f && entry_q[idx_f].ctr[1];
  assign predict_targetF = predict_takenF ? entry_q[idx_f].target : pcF + 32'd4;

  assign hit_e = entry_q[idx_e].valid && (entry_q[idx_e].tag == tag_e);

  sat_counter2 u_sat_counter2 (
    .ctr      (entry_q[idx_e].ctr),
    .taken    (br_takenE),
    .ctr_next (ctr_next)
  );

  assign mispredictE = update_validE && !rst &&
                       ((predicted_takenE != br_takenE) ||
                        (br_takenE && (predicted_targetE != targetE)));
  assign redirect_pcE = !update_validE ? 32'd0 :
                        br_takenE      ? targetE : pcE + 32'd4;

  // Table update: train on hit, allocate only on taken miss.
  always_comb begin
    entry_d = entry_q;
    if (update_validE) begin
      if (hit_e) begin
        entry_d[idx_e].ctr = ctr_next;
        if (br_takenE) begin
          entry_d[idx_e].target = targetE;
        end
      end else if (br_takenE) begin
        entry_d[idx_e] = '{valid: 1'b1, tag: tag_e, target: targetE, ctr: WT};
      end
    end
  end

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (update_validE && (branch_cnt_q != 32'hFFFF_FFFF)) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
    end
    if (mispredictE && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
      mispred_cnt_d = mispred_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        entry_q[i] <= ENTRY_RESET;
      end
      branch_cnt_q  <= 32'd0;
      mispred_cnt_q <= 32'd0;
    end else begin
      entry_q       <= entry_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor with a queue-based scoreboard and negedge monitor.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] pcF;
  logic        predict_takenF;
  logic [31:0] predict_targetF;
  logic        update_validE;
  logic [31:0] pcE;
  logic        br_takenE;
  logic [31:0] targetE;
  logic        predicted_takenE;
  logic [31:0] predicted_targetE;
  logic        mispredictE;
  logic [31:0] redirect_pcE;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  branch_predictor #(.ENTRIES(64)) dut (
    .clk               (clk),
    .rst               (rst),
    .pcF               (pcF),
    .predict_takenF    (predict_takenF),
    .predict_targetF   (predict_targetF),
    .update_validE     (update_validE),
    .pcE               (pcE),
    .br_takenE         (br_takenE),
    .targetE           (targetE),
    .predicted_takenE  (predicted_takenE),
    .predicted_targetE (predicted_targetE),
    .mispredictE       (mispredictE),
    .redirect_pcE      (redirect_pcE),
    .branch_cnt        (branch_cnt),
    .mispred_cnt       (mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        pt;
    logic [31:0] ptgt;
    logic        mis;
    logic [31:0] rpc;
    logic        chk_rpc;
    logic [31:0] bcnt;
    logic [31:0] mcnt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec  = 0;
  int          n_fail = 0;
  logic [31:0] exp_b  = 32'd0;
  logic [31:0] exp_m  = 32'd0;

  // Monitor: one expected record per presented vector, compared mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      logic bad;
      e   = sb_q.pop_front();
      bad = (predict_takenF !== e.pt) || (predict_targetF !== e.ptgt) ||
            (mispredictE !== e.mis) || (e.chk_rpc && (redirect_pcE !== e.rpc)) ||
            (branch_cnt !== e.bcnt) || (mispred_cnt !== e.mcnt);
      n_vec++;
      if (bad) begin
        n_fail++;
        $display("FAIL %s: got pt=%0b tgt=%h mis=%0b rpc=%h bcnt=%0d mcnt=%0d, want pt=%0b tgt=%h mis=%0b rpc=%h(chk=%0b) bcnt=%0d mcnt=%0d",
                 e.name, predict_takenF, predict_targetF, mispredictE, redirect_pcE,
                 branch_cnt, mispred_cnt, e.pt, e.ptgt, e.mis, e.rpc, e.chk_rpc, e.bcnt, e.mcnt);
      end
    end
  end

  task automatic vec(input string name, input logic r, input logic [31:0] pcf,
                     input logic upd, input logic [31:0] pce, input logic tk,
                     input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                     input logic e_pt, input logic [31:0] e_ptgt, input logic e_mis,
                     input logic [31:0] e_rpc, input logic chk_rpc);
    exp_t e;
    @(posedge clk);
    #1;
    rst               = r;
    pcF               = pcf;
    update_validE     = upd;
    pcE               = pce;
    br_takenE         = tk;
    targetE           = tgt;
    predicted_takenE  = ptk;
    predicted_targetE = ptgt;
    if (r) begin
      exp_b = 32'd0;
      exp_m = 32'd0;
    end
    e = '{name: name, pt: e_pt, ptgt: e_ptgt, mis: e_mis, rpc: e_rpc,
          chk_rpc: chk_rpc, bcnt: exp_b, mcnt: exp_m};
    sb_q.push_back(e);
    if (!r && upd) exp_b = exp_b + 32'd1;
    if (!r && e_mis) exp_m = exp_m + 32'd1;
  endtask

  initial begin
    rst = 1'b1; pcF = 32'd0; update_validE = 1'b0; pcE = 32'd0; br_takenE = 1'b0;
    targetE = 32'd0; predicted_takenE = 1'b0; predicted_targetE = 32'd0;
    repeat (2) @(posedge clk);

    //   name               rst  pcF           upd pcE    tk  tgt     ptk ptgt    e_pt e_ptgt        mis rpc     chk
    vec("reset",            1, 32'h100,       0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h104,       0, 32'h0,   0);
    vec("cold_lookup",      0, 32'h100,       0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h104,       0, 32'h0,   1);
    vec("first_taken",      0, 32'h100,       1, 32'h100, 1, 32'h200, 0, 32'h104, 0, 32'h104,       1, 32'h200, 1);
    vec("alloc_visible",    0, 32'h100,       0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h200,       0, 32'h0,   1);
    vec("wt_to_st",         0, 32'h100,       1, 32'h100, 1, 32'h200, 1, 32'h200, 1, 32'h200,       0, 32'h200, 1);
    vec("st_to_wt",         0, 32'h100,       1, 32'h100, 0, 32'h0,   1, 32'h200, 1, 32'h200,       1, 32'h104, 1);
    vec("wt_to_wnt_old",    0, 32'h100,       1, 32'h100, 0, 32'h0,   1, 32'h200, 1, 32'h200,       1, 32'h104, 1);
    vec("flip_after_2nt",   0, 32'h100,       0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h104,       0, 32'h0,   1);
    vec("wnt_to_snt",       0, 32'h104,       1, 32'h100, 0, 32'h0,   0, 32'h104, 0, 32'h108,       0, 32'h104, 1);
    vec("snt_saturate",     0, 32'h100,       1, 32'h100, 0, 32'h0,   0, 32'h104, 0, 32'h104,       0, 32'h104, 1);
    vec("snt_to_wnt",       0, 32'h100,       1, 32'h100, 1, 32'h200, 0, 32'h104, 0, 32'h104,       1, 32'h200, 1);
    vec("wnt_not_taken",    0, 32'h100,       0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h104,       0, 32'h0,   1);
    vec("alias_alloc",      0, 32'h100,       1, 32'h200, 1, 32'h600, 0, 32'h204, 0, 32'h104,       1, 32'h600, 1);
    vec("alias_miss",       0, 32'h100,       0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h104,       0, 32'h0,   1);
    vec("alias_hit",        0, 32'h200,       0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h600,       0, 32'h0,   1);
    vec("miss_nt_nochg",    0, 32'h200,       1, 32'h100, 0, 32'h0,   0, 32'h104, 1, 32'h600,       0, 32'h104, 1);
    vec("miss_nt_after",    0, 32'h200,       0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h600,       0, 32'h0,   1);
    vec("jalr_first",       0, 32'h300,       1, 32'h300, 1, 32'h400, 0, 32'h304, 0, 32'h304,       1, 32'h400, 1);
    vec("jalr_retarget",    0, 32'h300,       1, 32'h300, 1, 32'h500, 1, 32'h400, 1, 32'h400,       1, 32'h500, 1);
    vec("jalr_new_tgt",     0, 32'h300,       1, 32'h304, 0, 32'h0,   0, 32'h999, 1, 32'h500,       0, 32'h308, 1);
    vec("nt_tgt_ignored",   0, 32'h304,       0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h308,       0, 32'h0,   1);
    vec("pc_wrap",          0, 32'hFFFF_FFFC, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h0,         0, 32'h0,   1);
    vec("rst_mid_update",   1, 32'h300,       1, 32'h300, 1, 32'h700, 1, 32'h500, 0, 32'h304,       0, 32'h0,   0);
    vec("after_rst_clear",  0, 32'h300,       0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h304,       0, 32'h0,   1);
    vec("retrain",          0, 32'h100,       1, 32'h100, 1, 32'h200, 0, 32'h104, 0, 32'h104,       1, 32'h200, 1);
    vec("retrain_visible",  0, 32'h100,       0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h200,       0, 32'h0,   1);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected vectors never checked, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
